// File: rtl/prefetcher_tag_queue.sv
// Circular tag queue tracking one entry per prefetch/master AXI read burst for the prefetch controller.
// Ops take effect at the clock edge and status is visible the next cycle; no backpressure, illegal ops only set pr_err.
module prefetcher_tag_queue #(
  parameter int ADDR_BITS       = 64,
  parameter int LOG_QUEUE_SIZE  = 6,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int AF_MARGIN       = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       pr_flush,
  input  logic [2:0]                 pr_opCode,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  input  logic [ADDR_BITS-1:0]       stride,
  output logic                       pr_addrHit,
  output logic                       pr_hasOutstanding,
  output logic [LOG_QUEUE_SIZE:0]    pr_reqCnt,
  output logic                       pr_almostFull,
  output logic                       pr_context_valid,
  output logic                       pr_r_valid,
  output logic [ADDR_BITS-1:0]       pr_m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] pr_m_ar_len,
  output logic [TID_WIDTH-1:0]       pr_m_ar_id,
  output logic [LOG_QUEUE_SIZE-1:0]  head_idx,
  output logic [LOG_QUEUE_SIZE-1:0]  fill_idx,
  output logic                       pr_err
);

  localparam int DEPTH = 1 << LOG_QUEUE_SIZE;
  localparam int PW    = LOG_QUEUE_SIZE + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LIM  = PW'(AF_MARGIN);

  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_REQ_PREF     = 3'd1;
  localparam logic [2:0] OP_REQ_MASTER   = 3'd2;
  localparam logic [2:0] OP_DATA_SLAVE   = 3'd3;
  localparam logic [2:0] OP_DATA_PROMISE = 3'd4;

  logic [PW-1:0]                head, tail, claim, fill;
  logic [DEPTH-1:0]             ent_vld, ent_claimed, ent_data;
  logic [ADDR_BITS-1:0]         ent_addr [DEPTH];
  logic [ADDR_BITS-1:0]         last_addr;
  logic                         ctx_vld;
  logic [BURST_LEN_WIDTH-1:0]   ctx_len;
  logic [TID_WIDTH-1:0]         ctx_id;

  logic [LOG_QUEUE_SIZE-1:0] tail_i, claim_i;
  logic                      q_full, claim_ok, fill_ok;
  logic [PW-1:0]             free_cnt;

  logic                 push_en, push_claimed, claim_en, fill_en, pop_en, illegal;
  logic [ADDR_BITS-1:0] push_addr;

  assign tail_i   = tail[LOG_QUEUE_SIZE-1:0];
  assign claim_i  = claim[LOG_QUEUE_SIZE-1:0];
  assign head_idx = head[LOG_QUEUE_SIZE-1:0];
  assign fill_idx = fill[LOG_QUEUE_SIZE-1:0];

  assign q_full = (head_idx == tail_i) && (head[LOG_QUEUE_SIZE] != tail[LOG_QUEUE_SIZE]);

  // claim ptr always rests on the oldest unclaimed entry, or on tail when there is none
  assign claim_ok = (claim != tail) && ent_vld[claim_i] && !ent_claimed[claim_i];
  assign fill_ok  = (fill != tail) && ent_vld[fill_idx] && !ent_data[fill_idx];

  assign pr_addrHit        = claim_ok && (ent_addr[claim_i] == s_ar_addr);
  assign pr_hasOutstanding = fill_ok;
  assign pr_r_valid        = (head != tail) && ent_vld[head_idx] && ent_claimed[head_idx] && ent_data[head_idx];
  assign pr_reqCnt         = tail - head;
  assign free_cnt          = DEPTH_P - pr_reqCnt;
  assign pr_almostFull     = (free_cnt <= AF_LIM);
  assign pr_m_ar_addr      = last_addr + stride;
  assign pr_context_valid  = ctx_vld;
  assign pr_m_ar_len       = ctx_len;
  assign pr_m_ar_id        = ctx_id;

  always_comb begin
    push_en      = 1'b0;
    push_claimed = 1'b0;
    push_addr    = pr_m_ar_addr;
    claim_en     = 1'b0;
    fill_en      = 1'b0;
    pop_en       = 1'b0;
    illegal      = 1'b0;
    case (pr_opCode)
      OP_NOP: ;
      OP_REQ_PREF: begin
        if (q_full) illegal = 1'b1;
        else        push_en = 1'b1;
      end
      OP_REQ_MASTER: begin
        if (pr_addrHit) begin
          claim_en = 1'b1;
        end else if (q_full) begin
          illegal = 1'b1;
        end else begin
          push_en      = 1'b1;
          push_claimed = 1'b1;
          push_addr    = s_ar_addr;
        end
      end
      OP_DATA_SLAVE: begin
        if (fill_ok) fill_en = 1'b1;
        else         illegal = 1'b1;
      end
      OP_DATA_PROMISE: begin
        if (pr_r_valid) pop_en  = 1'b1;
        else            illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head        <= '0;
      tail        <= '0;
      claim       <= '0;
      fill        <= '0;
      ent_vld     <= '0;
      ent_claimed <= '0;
      ent_data    <= '0;
      last_addr   <= '0;
      ctx_vld     <= 1'b0;
      ctx_len     <= '0;
      ctx_id      <= '0;
      pr_err      <= 1'b0;
    end else if (pr_flush) begin
      head        <= '0;
      tail        <= '0;
      claim       <= '0;
      fill        <= '0;
      ent_vld     <= '0;
      ent_claimed <= '0;
      ent_data    <= '0;
      last_addr   <= '0;
      ctx_vld     <= 1'b0;
      ctx_len     <= '0;
      ctx_id      <= '0;
    end else begin
      if (illegal) pr_err <= 1'b1;
      if (push_en) begin
        ent_vld[tail_i]     <= 1'b1;
        ent_claimed[tail_i] <= push_claimed;
        ent_data[tail_i]    <= 1'b0;
        tail                <= tail + 1'b1;
        last_addr           <= push_addr;
        // an unmatched master request skips any pending unclaimed prefetches
        if (push_claimed) claim <= tail + 1'b1;
      end
      if (claim_en) begin
        ent_claimed[claim_i] <= 1'b1;
        claim                <= claim + 1'b1;
      end
      if (fill_en) begin
        ent_data[fill_idx] <= 1'b1;
        fill               <= fill + 1'b1;
      end
      if (pop_en) begin
        ent_vld[head_idx] <= 1'b0;
        head              <= head + 1'b1;
      end
      if ((pr_opCode == OP_REQ_MASTER) && !illegal && !ctx_vld) begin
        ctx_vld <= 1'b1;
        ctx_len <= s_ar_len;
        ctx_id  <= s_ar_id;
      end
    end
  end

  // addresses are qualified by ent_vld, so the storage itself needs no reset
  always_ff @(posedge clk) begin
    if (push_en && !pr_flush) ent_addr[tail_i] <= push_addr;
  end

endmodule

// File: tb/tb_prefetcher_tag_queue.sv
// Directed bench for prefetcher_tag_queue: one task per scenario, inline comparisons against hand-computed values.
module tb_prefetcher_tag_queue;

  localparam logic [2:0] OP_NOP = 3'd0, OP_PREF = 3'd1, OP_MASTER = 3'd2, OP_DSLAVE = 3'd3, OP_PROMISE = 3'd4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        pr_flush;
  logic [2:0]  pr_opCode;
  logic [63:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [7:0]  s_ar_id;
  logic [63:0] stride;
  logic        pr_addrHit, pr_hasOutstanding, pr_almostFull, pr_context_valid, pr_r_valid, pr_err;
  logic [6:0]  pr_reqCnt;
  logic [63:0] pr_m_ar_addr;
  logic [7:0]  pr_m_ar_len, pr_m_ar_id;
  logic [5:0]  head_idx, fill_idx;

  int n_cmp = 0;
  int n_bad = 0;

  prefetcher_tag_queue dut (
    .clk(clk), .resetN(resetN), .pr_flush(pr_flush), .pr_opCode(pr_opCode),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id), .stride(stride),
    .pr_addrHit(pr_addrHit), .pr_hasOutstanding(pr_hasOutstanding), .pr_reqCnt(pr_reqCnt),
    .pr_almostFull(pr_almostFull), .pr_context_valid(pr_context_valid), .pr_r_valid(pr_r_valid),
    .pr_m_ar_addr(pr_m_ar_addr), .pr_m_ar_len(pr_m_ar_len), .pr_m_ar_id(pr_m_ar_id),
    .head_idx(head_idx), .fill_idx(fill_idx), .pr_err(pr_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [2:0] op, input logic [63:0] addr);
    @(negedge clk);
    pr_opCode = op;
    s_ar_addr = addr;
    @(posedge clk);
    #1;
    pr_opCode = OP_NOP;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; pr_flush = 1'b0; pr_opCode = OP_NOP;
    s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0; stride = '0;
    #12;
    n_cmp++; if (pr_reqCnt !== 7'd0) begin n_bad++; $display("FAIL reset_reqcnt: got %0d want 0", pr_reqCnt); end
    n_cmp++; if ({pr_almostFull, pr_hasOutstanding, pr_r_valid, pr_context_valid, pr_addrHit, pr_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {pr_almostFull, pr_hasOutstanding, pr_r_valid, pr_context_valid, pr_addrHit, pr_err}); end
    n_cmp++; if ({pr_m_ar_addr, pr_m_ar_len, pr_m_ar_id} !== 80'd0) begin
      n_bad++; $display("FAIL reset_m_ar: got %h/%h/%h want 0", pr_m_ar_addr, pr_m_ar_len, pr_m_ar_id); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_master();
    s_ar_len = 8'd4; s_ar_id = 8'd3;
    for (int i = 0; i < 3; i++) step(OP_MASTER, 64'hdeadbeef + 64'(64 * i));
    n_cmp++; if (pr_reqCnt !== 7'd3) begin n_bad++; $display("FAIL master_reqcnt: got %0d want 3", pr_reqCnt); end
    n_cmp++; if ({pr_context_valid, pr_m_ar_len, pr_m_ar_id} !== {1'b1, 8'd4, 8'd3}) begin
      n_bad++; $display("FAIL master_ctx: got v=%b len=%0d id=%0d want v=1 len=4 id=3", pr_context_valid, pr_m_ar_len, pr_m_ar_id); end
    n_cmp++; if ({pr_hasOutstanding, pr_r_valid} !== 2'b10) begin
      n_bad++; $display("FAIL master_outstanding: got %b want 10", {pr_hasOutstanding, pr_r_valid}); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (fill_idx !== 6'(i)) begin n_bad++; $display("FAIL fill_idx: got %0d want %0d", fill_idx, i); end
      step(OP_DSLAVE, '0);
    end
    n_cmp++; if ({pr_hasOutstanding, pr_r_valid} !== 2'b01) begin
      n_bad++; $display("FAIL data_arrived: got %b want 01", {pr_hasOutstanding, pr_r_valid}); end
    for (int i = 0; i < 3; i++) step(OP_PROMISE, '0);
    n_cmp++; if ({pr_reqCnt, pr_r_valid, head_idx} !== {7'd0, 1'b0, 6'd3}) begin
      n_bad++; $display("FAIL pop_state: got cnt=%0d rv=%b head=%0d want 0/0/3", pr_reqCnt, pr_r_valid, head_idx); end
    n_cmp++; if (pr_err !== 1'b0) begin n_bad++; $display("FAIL master_err: got %b want 0", pr_err); end
  endtask

  task automatic test_pref_hit();
    stride = 64'd64;
    #1;
    n_cmp++; if (pr_m_ar_addr !== 64'hdeadbfaf) begin n_bad++; $display("FAIL pref_addr0: got %h want deadbfaf", pr_m_ar_addr); end
    step(OP_PREF, '0);
    n_cmp++; if (pr_m_ar_addr !== 64'hdeadbfef) begin n_bad++; $display("FAIL pref_addr1: got %h want deadbfef", pr_m_ar_addr); end
    step(OP_PREF, '0);
    n_cmp++; if ({pr_reqCnt, pr_m_ar_addr} !== {7'd2, 64'hdeadc02f}) begin
      n_bad++; $display("FAIL pref_push2: got cnt=%0d addr=%h want 2/deadc02f", pr_reqCnt, pr_m_ar_addr); end
    @(negedge clk); s_ar_addr = 64'hdeadbfaf; #1;
    n_cmp++; if (pr_addrHit !== 1'b1) begin n_bad++; $display("FAIL hit_oldest: got %b want 1", pr_addrHit); end
    s_ar_addr = 64'hdeadbfef; #1;
    n_cmp++; if (pr_addrHit !== 1'b0) begin n_bad++; $display("FAIL hit_younger: got %b want 0", pr_addrHit); end
    step(OP_MASTER, 64'hdeadbfaf);
    n_cmp++; if ({pr_reqCnt, pr_m_ar_addr, pr_err, pr_r_valid} !== {7'd2, 64'hdeadc02f, 2'b00}) begin
      n_bad++; $display("FAIL claim_nopush: got cnt=%0d addr=%h err=%b rv=%b want 2/deadc02f/0/0", pr_reqCnt, pr_m_ar_addr, pr_err, pr_r_valid); end
    s_ar_addr = 64'hdeadbfef; #1;
    n_cmp++; if (pr_addrHit !== 1'b1) begin n_bad++; $display("FAIL hit_next: got %b want 1", pr_addrHit); end
    stride = 64'hffff_ffff_ffff_ffc0; #1;
    n_cmp++; if (pr_m_ar_addr !== 64'hdeadbfaf) begin n_bad++; $display("FAIL neg_stride: got %h want deadbfaf", pr_m_ar_addr); end
    stride = 64'h3000_0000_0000_0000; #1;
    n_cmp++; if (pr_m_ar_addr !== 64'h3000_0000_dead_bfef) begin n_bad++; $display("FAIL big_stride: got %h want 30000000deadbfef", pr_m_ar_addr); end
    stride = 64'd64;
  endtask

  task automatic test_flush();
    @(negedge clk);
    pr_flush = 1'b1; pr_opCode = OP_PREF;
    @(posedge clk); #1;
    pr_flush = 1'b0; pr_opCode = OP_NOP;
    n_cmp++; if ({pr_reqCnt, pr_context_valid, pr_hasOutstanding, head_idx, fill_idx} !== 21'd0) begin
      n_bad++; $display("FAIL flush_state: got cnt=%0d ctx=%b out=%b head=%0d fill=%0d want all 0",
                        pr_reqCnt, pr_context_valid, pr_hasOutstanding, head_idx, fill_idx); end
    n_cmp++; if (pr_m_ar_addr !== 64'd64) begin n_bad++; $display("FAIL flush_last_addr: got %h want 40", pr_m_ar_addr); end
    s_ar_addr = 64'hdeadc02f; #1;
    n_cmp++; if ({pr_addrHit, pr_err} !== 2'b00) begin n_bad++; $display("FAIL flush_no_entry: got hit/err=%b want 00", {pr_addrHit, pr_err}); end
  endtask

  task automatic test_fill_wrap();
    s_ar_len = 8'd4; s_ar_id = 8'd3;
    for (int i = 0; i < 64; i++) begin
      step(OP_MASTER, 64'h10_0000 + 64'(16 * i));
      if (i == 60) begin
        n_cmp++; if (pr_almostFull !== 1'b0) begin n_bad++; $display("FAIL af_at_61: got %b want 0", pr_almostFull); end
      end
      if (i == 61) begin
        n_cmp++; if (pr_almostFull !== 1'b1) begin n_bad++; $display("FAIL af_at_62: got %b want 1", pr_almostFull); end
      end
    end
    n_cmp++; if ({pr_reqCnt, pr_err} !== {7'd64, 1'b0}) begin
      n_bad++; $display("FAIL full_64: got cnt=%0d err=%b want 64/0", pr_reqCnt, pr_err); end
    step(OP_MASTER, 64'h20_0000);
    n_cmp++; if ({pr_reqCnt, pr_err} !== {7'd64, 1'b1}) begin
      n_bad++; $display("FAIL overflow: got cnt=%0d err=%b want 64/1", pr_reqCnt, pr_err); end
    for (int i = 0; i < 70; i++) begin
      step(OP_DSLAVE, '0);
      step(OP_PROMISE, '0);
      step(OP_MASTER, 64'h30_0000 + 64'(16 * i));
    end
    n_cmp++; if ({pr_reqCnt, head_idx, fill_idx, pr_r_valid, pr_hasOutstanding} !== {7'd64, 6'd6, 6'd6, 2'b01}) begin
      n_bad++; $display("FAIL wrap_state: got cnt=%0d head=%0d fill=%0d rv=%b out=%b want 64/6/6/0/1",
                        pr_reqCnt, head_idx, fill_idx, pr_r_valid, pr_hasOutstanding); end
    n_cmp++; if (pr_m_ar_addr !== 64'h30_0490) begin n_bad++; $display("FAIL wrap_m_ar: got %h want 300490", pr_m_ar_addr); end
    for (int i = 0; i < 64; i++) step(OP_DSLAVE, '0);
    n_cmp++; if ({fill_idx, pr_hasOutstanding, pr_r_valid} !== {6'd6, 2'b01}) begin
      n_bad++; $display("FAIL drain_fill: got fill=%0d out=%b rv=%b want 6/0/1", fill_idx, pr_hasOutstanding, pr_r_valid); end
    for (int i = 0; i < 64; i++) step(OP_PROMISE, '0);
    n_cmp++; if ({pr_reqCnt, head_idx, pr_r_valid, pr_almostFull} !== {7'd0, 6'd6, 2'b00}) begin
      n_bad++; $display("FAIL drain_pop: got cnt=%0d head=%0d rv=%b af=%b want 0/6/0/0", pr_reqCnt, head_idx, pr_r_valid, pr_almostFull); end
  endtask

  task automatic test_illegal();
    pulse_reset();
    #1;
    n_cmp++; if (pr_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", pr_err); end
    step(3'd7, '0);
    n_cmp++; if ({pr_err, pr_reqCnt} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL bad_opcode: got err=%b cnt=%0d want 1/0", pr_err, pr_reqCnt); end
    pulse_reset();
    step(OP_PROMISE, '0);
    n_cmp++; if ({pr_err, head_idx} !== {1'b1, 6'd0}) begin n_bad++; $display("FAIL pop_empty: got err=%b head=%0d want 1/0", pr_err, head_idx); end
    pulse_reset();
    step(OP_DSLAVE, '0);
    n_cmp++; if ({pr_err, fill_idx} !== {1'b1, 6'd0}) begin n_bad++; $display("FAIL fill_empty: got err=%b fill=%0d want 1/0", pr_err, fill_idx); end
    step(OP_PREF, '0);
    step(OP_PROMISE, '0);
    n_cmp++; if ({pr_reqCnt, head_idx} !== {7'd1, 6'd0}) begin n_bad++; $display("FAIL pop_unclaimed: got cnt=%0d head=%0d want 1/0", pr_reqCnt, head_idx); end
    @(negedge clk); pr_flush = 1'b1; @(posedge clk); #1; pr_flush = 1'b0;
    n_cmp++; if ({pr_err, pr_reqCnt} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL flush_keeps_err: got err=%b cnt=%0d want 1/0", pr_err, pr_reqCnt); end
  endtask

  task automatic test_async_reset();
    stride = '0;
    step(OP_MASTER, 64'h40);
    step(OP_MASTER, 64'h80);
    step(OP_DSLAVE, '0);
    n_cmp++; if ({pr_reqCnt, pr_r_valid, pr_context_valid} !== {7'd2, 2'b11}) begin
      n_bad++; $display("FAIL pre_reset: got cnt=%0d rv=%b ctx=%b want 2/1/1", pr_reqCnt, pr_r_valid, pr_context_valid); end
    @(negedge clk); #1;
    resetN = 1'b0;
    #1;
    n_cmp++; if ({pr_reqCnt, pr_r_valid, pr_context_valid, pr_hasOutstanding, pr_err, pr_almostFull} !== 12'd0) begin
      n_bad++; $display("FAIL async_reset: got cnt=%0d rv=%b ctx=%b out=%b err=%b af=%b want all 0",
                        pr_reqCnt, pr_r_valid, pr_context_valid, pr_hasOutstanding, pr_err, pr_almostFull); end
    n_cmp++; if ({pr_m_ar_addr, pr_m_ar_len, pr_m_ar_id, head_idx, fill_idx} !== 92'd0) begin
      n_bad++; $display("FAIL async_reset_m_ar: got %h/%h/%h head=%0d fill=%0d want 0", pr_m_ar_addr, pr_m_ar_len, pr_m_ar_id, head_idx, fill_idx); end
    #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({pr_reqCnt, pr_r_valid} !== {7'd0, 1'b0}) begin
      n_bad++; $display("FAIL post_reset: got cnt=%0d rv=%b want 0/0", pr_reqCnt, pr_r_valid); end
  endtask

  initial begin
    test_reset();
    test_master();
    test_pref_hit();
    test_flush();
    test_fill_wrap();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
